mips_hazard_ctrl: RTL
=====================

// Module: mips_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS datapath. Drives pcwrite, ifidwrite, nop, ifflush, pcsrc, fw1 and fw2,
//  plus a new pipe_freeze for multi-cycle data memory. Handles load-use stalls, branches resolved in ID, jumps,
//  EX-stage forwarding and data-memory wait states. Also keeps a saturating stall-cycle counter.
// PARAMETERS
//  MAX_WAIT  16  data-memory wait cycles before timeout (>=1)
//  CNT_W     16  stall counter width
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-low reset
//  id_rs,id_rt  in   5      IF/ID instruction rs/rt fields
//  id_uses_rt   in   1      ID instruction reads rt (R-type, beq, sw)
//  id_branch    in   1      ID instruction is beq
//  id_jump      in   1      ID instruction is j
//  equal        in   1      register-file compare of rs/rt (ID)
//  ex_rs,ex_rt  in   5      ID/EX rs/rt fields
//  ex_rd        in   5      ID/EX destination after regdst mux
//  ex_memread   in   1      ID/EX memread
//  ex_regwrite  in   1      ID/EX regwrite
//  mem_rd       in   5      EX/MEM destination
//  mem_regwrite in   1      EX/MEM regwrite
//  mem_access   in   1      EX/MEM memread|memwrite
//  dmem_ready   in   1      data memory completes the access this cycle
//  wb_rd        in   5      MEM/WB destination
//  wb_regwrite  in   1      MEM/WB regwrite
//  cnt_clr      in   1      synchronous clear of stall_cnt
//  pcwrite      out  1      PC load enable
//  ifidwrite    out  1      IF/ID load enable
//  ifflush      out  1      zero IF/ID on the next edge
//  nop          out  1      zero ID/EX control bits (bubble)
//  pipe_freeze  out  1      hold ID/EX, EX/MEM, MEM/WB and block regfile/memory writes
//  pcsrc        out  2      0 = PC+4, 1 = branch target, 2 = jump target
//  fw1,fw2      out  2      ALU operand select: 0 = ID/EX data, 1 = WB data, 2 = EX/MEM ALU result
//  mem_err      out  1      sticky memory-timeout flag
//  stall_cnt    out  CNT_W  cycles with pcwrite = 0
// BEHAVIOUR
//  Reset (rst = 0, async): state RUN, wait counter 0, mem_err 0, stall_cnt 0.
//   While rst is low: pcwrite=ifidwrite=1; all other outputs 0.
//  Control outputs are combinational from state and inputs; they act on the same cycle.
//  States: RUN, BR_WAIT1, MEM_WAIT.
//  Hazard terms (register 0 never matches):
//   lu  = ex_memread & ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)
//   brx = id_branch & ex_regwrite & ex_rd matches id_rs | id_rt
//   brm = id_branch & mem_regwrite & mem_rd matches id_rs | id_rt
//  Priority (first match wins):
//   1. mem_access & !dmem_ready: freeze=1, pcwrite=ifidwrite=0, nop=0, pcsrc=0; go to MEM_WAIT.
//   2. lu | brx | brm: pcwrite=ifidwrite=0, nop=1.
//      brx caused by a load (ex_memread) goes to BR_WAIT1: one more forced stall cycle, then back to RUN.
//   3. id_branch & equal: pcsrc=1, ifflush=1.
//   4. id_jump: pcsrc=2, ifflush=1.
//   5. Otherwise: pcsrc=0, pcwrite=ifidwrite=1.
//  BR_WAIT1 still yields to rule 1 (MEM_WAIT beats it). After MEM_WAIT, rules are re-evaluated.
//  MEM_WAIT: exit to RUN on dmem_ready; that cycle is not frozen.
//   The wait counter counts frozen cycles. At MAX_WAIT, set mem_err, drop freeze, return to RUN.
//   mem_err clears only on reset.
//  Forwarding is evaluated in every state:
//   fw1 = 2 if mem_regwrite & mem_rd!=0 & mem_rd==ex_rs;
//       else 1 if wb_regwrite & wb_rd!=0 & wb_rd==ex_rs;
//       else 0. fw2 is the same using ex_rt. EX/MEM wins over WB; value 3 is never driven.
//  stall_cnt: +1 on each clock edge where pcwrite=0; saturates at all-ones, no wrap.
//   cnt_clr wins over increment.
//  Reset mid-stall or mid-wait: abort to RUN immediately; no partial-state carry-over.
// STRUCTURE
//  Package mips_pkg: state enum, PCSRC_SEQ/BR/JMP, FW_REG/FW_WB/FW_MEM constants.
//  Sub-module mips_fwd_unit: purely combinational fw1/fw2 logic, reusable.
//  FSM, wait counter and stall counter sit at top level.
// TESTING
//  T1 lw $2 in EX (ex_memread=1, ex_rt=2); ID add rs=2
//     -> 1 cycle pcwrite=ifidwrite=0, nop=1; stall_cnt=1.
//  T2 beq rs=3 in ID; lw ex_rd=3 in EX
//     -> 2 stall cycles (RUN then BR_WAIT1), then equal=1 gives pcsrc=1, ifflush=1.
//  T3 mem_rd=wb_rd=5, ex_rs=5, both regwrite=1 -> fw1=2.
//     mem_rd=0 -> fw1=1. ex_rt=0 -> fw2=0.
//  T4 mem_access=1, dmem_ready low 3 cycles -> freeze 3 cycles, then RUN. No nop; mem_err=0.
//  T5 MAX_WAIT=4, dmem_ready never -> freeze 4 cycles; mem_err=1 stays set; RUN resumes.
//  T6 rst low mid-MEM_WAIT -> freeze=0 and stall_cnt=0 immediately (async).
//     Force stall_cnt to all-ones (CNT_W=4) -> holds 15.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and encodings for the MIPS pipeline hazard control
package mips_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_WAIT1 = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JMP = 2'd2;

    localparam logic [1:0] FW_REG = 2'd0;
    localparam logic [1:0] FW_WB  = 2'd1;
    localparam logic [1:0] FW_MEM = 2'd2;

    // $zero is hardwired, so it never creates a dependency
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

endpackage

// File: rtl/mips_hazard_ctrl_if.sv
// rtl/mips_hazard_ctrl_if.sv - pipeline-state inputs and control outputs of the hazard controller
interface mips_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             id_uses_rt, id_branch, id_jump, equal;
    logic             ex_memread, ex_regwrite, mem_regwrite, mem_access, dmem_ready, wb_regwrite;
    logic             cnt_clr;
    logic             pcwrite, ifidwrite, ifflush, nop, pipe_freeze, mem_err;
    logic [1:0]       pcsrc, fw1, fw2;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
        output id_uses_rt, id_branch, id_jump, equal,
        output ex_memread, ex_regwrite, mem_regwrite, mem_access, dmem_ready, wb_regwrite,
        output cnt_clr,
        input  pcwrite, ifidwrite, ifflush, nop, pipe_freeze, mem_err,
        input  pcsrc, fw1, fw2, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd,
        input  id_uses_rt, id_branch, id_jump, equal,
        input  ex_memread, ex_regwrite, mem_regwrite, mem_access, dmem_ready, wb_regwrite,
        input  cnt_clr,
        output pcwrite, ifidwrite, ifflush, nop, pipe_freeze, mem_err,
        output pcsrc, fw1, fw2, stall_cnt
    );
endinterface

// File: rtl/mips_fwd_unit.sv
// rtl/mips_fwd_unit.sv - combinational EX-stage operand forwarding select
module mips_fwd_unit
    import mips_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] mem_rd,
    input  logic [4:0] wb_rd,
    input  logic       mem_regwrite,
    input  logic       wb_regwrite,
    output logic [1:0] fw1,
    output logic [1:0] fw2
);
    // The younger EX/MEM result takes precedence over MEM/WB
    function automatic logic [1:0] fw_sel(input logic [4:0] src);
        if (mem_regwrite && reg_match(mem_rd, src))
            return FW_MEM;
        else if (wb_regwrite && reg_match(wb_rd, src))
            return FW_WB;
        else
            return FW_REG;
    endfunction

    assign fw1 = fw_sel(ex_rs);
    assign fw2 = fw_sel(ex_rt);
endmodule

// File: rtl/mips_hazard_ctrl.sv
// rtl/mips_hazard_ctrl.sv - stall/flush/freeze sequencer and stall counter for the 5-stage MIPS pipeline
module mips_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    mips_hazard_ctrl_if.slave hz
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    state_t           state, next_state;
    logic [WW-1:0]    wait_cnt;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             pcw, ifw, flush, bubble, frz, err_set, eval_rules;
    logic [1:0]       pcs, fw1_i, fw2_i;
    logic             lu, brx, brm, mem_stall;

    assign lu  = hz.ex_memread & (reg_match(hz.ex_rt, hz.id_rs) |
                                  (hz.id_uses_rt & reg_match(hz.ex_rt, hz.id_rt)));
    assign brx = hz.id_branch & hz.ex_regwrite &
                 (reg_match(hz.ex_rd, hz.id_rs) | reg_match(hz.ex_rd, hz.id_rt));
    assign brm = hz.id_branch & hz.mem_regwrite &
                 (reg_match(hz.mem_rd, hz.id_rs) | reg_match(hz.mem_rd, hz.id_rt));
    assign mem_stall = hz.mem_access & ~hz.dmem_ready;

    always_comb begin
        next_state = state;
        pcw        = 1'b1;
        ifw        = 1'b1;
        flush      = 1'b0;
        bubble     = 1'b0;
        frz        = 1'b0;
        pcs        = PCSRC_SEQ;
        err_set    = 1'b0;
        eval_rules = 1'b1;

        if (state == MEM_WAIT) begin
            if (hz.dmem_ready) begin
                next_state = RUN;
            end else if (wait_cnt == WW'(MAX_WAIT)) begin
                err_set    = 1'b1;
                next_state = RUN;
            end else begin
                frz        = 1'b1;
                pcw        = 1'b0;
                ifw        = 1'b0;
                eval_rules = 1'b0;
            end
        end

        // A cycle leaving MEM_WAIT skips the memory rule so a timeout really releases the pipe
        if (eval_rules) begin
            if (state != MEM_WAIT && mem_stall) begin
                frz        = 1'b1;
                pcw        = 1'b0;
                ifw        = 1'b0;
                next_state = MEM_WAIT;
            end else if (lu || brx || brm || state == BR_WAIT1) begin
                pcw        = 1'b0;
                ifw        = 1'b0;
                bubble     = 1'b1;
                next_state = (brx && hz.ex_memread) ? BR_WAIT1 : RUN;
            end else if (hz.id_branch && hz.equal) begin
                pcs        = PCSRC_BR;
                flush      = 1'b1;
                next_state = RUN;
            end else if (hz.id_jump) begin
                pcs        = PCSRC_JMP;
                flush      = 1'b1;
                next_state = RUN;
            end else begin
                next_state = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state     <= next_state;
            wait_cnt  <= (next_state == MEM_WAIT) ? wait_cnt + WW'(1) : '0;
            mem_err_q <= mem_err_q | err_set;
            if (hz.cnt_clr)
                stall_cnt_q <= '0;
            else if (!pcw && stall_cnt_q != {CNT_W{1'b1}})
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    mips_fwd_unit u_fwd (
        .ex_rs        (hz.ex_rs),
        .ex_rt        (hz.ex_rt),
        .mem_rd       (hz.mem_rd),
        .wb_rd        (hz.wb_rd),
        .mem_regwrite (hz.mem_regwrite),
        .wb_regwrite  (hz.wb_regwrite),
        .fw1          (fw1_i),
        .fw2          (fw2_i)
    );

    // While in reset the pipe free-runs with every other control forced idle
    assign hz.pcwrite     = pcw | ~rst;
    assign hz.ifidwrite   = ifw | ~rst;
    assign hz.ifflush     = flush & rst;
    assign hz.nop         = bubble & rst;
    assign hz.pipe_freeze = frz & rst;
    assign hz.pcsrc       = pcs & {2{rst}};
    assign hz.fw1         = fw1_i & {2{rst}};
    assign hz.fw2         = fw2_i & {2{rst}};
    assign hz.mem_err     = mem_err_q;
    assign hz.stall_cnt   = stall_cnt_q;
endmodule
